// File: rtl/board_fb_pkg.sv
// Shared constants, tile index type and arbiter FSM states for the board frame buffer.
// Optional clear feature: BOARD_FB_CLEAR_EN adds the StClear state.
package board_fb_pkg;

  localparam int unsigned TILE_W    = 17;
  localparam int unsigned NUM_TILES = 16;

  // Tile index {row, col} on the 4x4 board
  typedef logic [3:0] tile_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StPending,
    StCopy,
    StDone
`ifdef BOARD_FB_CLEAR_EN
    ,
    StClear
`endif
  } fb_state_e;

endpackage

// File: rtl/board_fb_regfile.sv
// Tile storage: one synchronous write port, two asynchronous read ports,
// synchronously cleared to zero on reset.
module board_fb_regfile #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  output logic [Width-1:0] rdata_a_o,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [Width-1:0] rdata_b_o
);

  logic [Width-1:0] mem_q [Depth];

  // Storage update: clear on reset, otherwise single write per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/board_fb_arbiter.sv
// Double-buffered tile store between game logic (shadow writes) and the VGA board
// renderer (front reads). Shadow is copied to front only during vertical blank.
// Optional feature macro: BOARD_FB_CLEAR_EN (adds clear_req/clear_done and StClear).
module board_fb_arbiter #(
  parameter int unsigned TILE_W    = board_fb_pkg::TILE_W,
  parameter int unsigned NUM_TILES = board_fb_pkg::NUM_TILES
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              pix_stb,
  input  logic              vblank,
  input  logic [1:0]        row,
  input  logic [1:0]        col,
  output logic [TILE_W-1:0] data,
  input  logic              wr_req,
  input  logic [3:0]        wr_addr,
  input  logic [TILE_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              commit_req,
  output logic              commit_done,
`ifdef BOARD_FB_CLEAR_EN
  input  logic              clear_req,
  output logic              clear_done,
`endif
  output logic              busy
);

  import board_fb_pkg::*;

  fb_state_e         state_q, state_d;
  tile_idx_t         idx_q, idx_d;
  logic              wr_ack_q;
  logic [TILE_W-1:0] data_q;
  logic              wr_take;
  logic              copy_en;
  logic              clear_en;
  logic              start_clear;

  logic              sh_we;
  tile_idx_t         sh_waddr;
  logic [TILE_W-1:0] sh_wdata;
  logic [TILE_W-1:0] sh_rdata;
  logic [TILE_W-1:0] front_rdata;
  logic [TILE_W-1:0] sh_rd_unused;
  logic [TILE_W-1:0] front_rd_unused;

`ifdef BOARD_FB_CLEAR_EN
  logic clear_done_q;
  assign start_clear = clear_req;
`else
  assign start_clear = 1'b0;
`endif

  // A write is taken only in IDLE, never in the cycle right after an ack, and never
  // when a commit (or clear) is requested in the same cycle.
  assign wr_take = (state_q == StIdle) && wr_req && !wr_ack_q && !commit_req && !start_clear;

  // State register and datapath registers
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      wr_ack_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ack_q <= wr_take;
      if (pix_stb) begin
        data_q <= front_rdata;
      end
    end
  end

`ifdef BOARD_FB_CLEAR_EN
  // clear_done pulses the cycle after the last shadow entry is zeroed
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= (state_q == StClear) && (idx_q == 4'hF);
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_clear) begin
`ifdef BOARD_FB_CLEAR_EN
          state_d = StClear;
`endif
        end else if (commit_req) begin
          state_d = StPending;
        end
      end
      StPending: if (vblank) state_d = StCopy;
      // Copy is atomic: vblank is not looked at once it has started
      StCopy:    if (idx_q == 4'hF) state_d = StDone;
      StDone:    state_d = StIdle;
`ifdef BOARD_FB_CLEAR_EN
      StClear:   if (idx_q == 4'hF) state_d = StIdle;
`endif
      default:   state_d = StIdle;
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    copy_en     = (state_q == StCopy);
`ifdef BOARD_FB_CLEAR_EN
    clear_en    = (state_q == StClear);
`else
    clear_en    = 1'b0;
`endif
    // idx wraps 15 -> 0 exactly as COPY/CLEAR is left
    idx_d       = (copy_en || clear_en) ? idx_q + 4'd1 : 4'd0;
    busy        = (state_q != StIdle);
    commit_done = (state_q == StDone);
    wr_ack      = wr_ack_q;
    data        = data_q;
    sh_we       = wr_take;
    sh_waddr    = wr_addr;
    sh_wdata    = wr_data;
    if (clear_en) begin
      sh_we    = 1'b1;
      sh_waddr = idx_q;
      sh_wdata = '0;
    end
  end

`ifdef BOARD_FB_CLEAR_EN
  assign clear_done = clear_done_q;
`endif

  board_fb_regfile #(
    .Width (TILE_W),
    .Depth (NUM_TILES)
  ) u_shadow (
    .clk_i     (CLK100MHZ),
    .rst_i     (reset),
    .we_i      (sh_we),
    .waddr_i   (sh_waddr),
    .wdata_i   (sh_wdata),
    .raddr_a_i (idx_q),
    .rdata_a_o (sh_rdata),
    .raddr_b_i (4'd0),
    .rdata_b_o (sh_rd_unused)
  );

  board_fb_regfile #(
    .Width (TILE_W),
    .Depth (NUM_TILES)
  ) u_front (
    .clk_i     (CLK100MHZ),
    .rst_i     (reset),
    .we_i      (copy_en),
    .waddr_i   (idx_q),
    .wdata_i   (sh_rdata),
    .raddr_a_i ({row, col}),
    .rdata_a_o (front_rdata),
    .raddr_b_i (idx_q),
    .rdata_b_o (front_rd_unused)
  );

endmodule

// File: tb/tb_board_fb_arbiter.sv
// Directed self-checking bench for board_fb_arbiter.
// Build with BOARD_FB_CLEAR_EN defined to also exercise the clear feature.
module tb_board_fb_arbiter;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        pix_stb = 1'b0;
  logic        vblank = 1'b0;
  logic [1:0]  row = '0;
  logic [1:0]  col = '0;
  logic [16:0] data;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [16:0] wr_data = '0;
  logic        wr_ack;
  logic        commit_req = 1'b0;
  logic        commit_done;
  logic        busy;
`ifdef BOARD_FB_CLEAR_EN
  logic        clear_req = 1'b0;
  logic        clear_done;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  board_fb_arbiter dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset       (reset),
    .pix_stb     (pix_stb),
    .vblank      (vblank),
    .row         (row),
    .col         (col),
    .data        (data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .commit_req  (commit_req),
    .commit_done (commit_done),
`ifdef BOARD_FB_CLEAR_EN
    .clear_req   (clear_req),
    .clear_done  (clear_done),
`endif
    .busy        (busy)
  );

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_tile(input logic [3:0] t, output logic [16:0] v);
    row     = t[3:2];
    col     = t[1:0];
    pix_stb = 1'b1;
    step();
    v       = data;
    pix_stb = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [16:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    check("write_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    step();
  endtask

  // Pulses commit_req with vblank high and returns cycles until commit_done (cap 40)
  task automatic do_commit(output int n);
    commit_req = 1'b1;
    vblank     = 1'b1;
    n          = 0;
    do begin
      step();
      commit_req = 1'b0;
      n++;
    end while (!commit_done && n < 40);
    vblank = 1'b0;
    step();
  endtask

  initial begin
    logic [16:0] v;
    int n;
    int seen;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_data", {15'd0, data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, wr_ack}, 32'd0);
    check("rst_done", {31'd0, commit_done}, 32'd0);
    for (int t = 0; t < 16; t++) begin
      read_tile(t[3:0], v);
      check("rst_tile", {15'd0, v}, 32'd0);
    end

    // Single write: ack one cycle later, front buffer unchanged
    wr_req  = 1'b1;
    wr_addr = 4'd5;
    wr_data = 17'h00800;
    step();
    check("wr_ack_1", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    step();
    check("wr_ack_pulse", {31'd0, wr_ack}, 32'd0);
    read_tile(4'd5, v);
    check("precommit_11", {15'd0, v}, 32'd0);

    // Held wr_req: ack, gap, ack
    wr_req  = 1'b1;
    wr_addr = 4'd3;
    wr_data = 17'h00777;
    step();
    check("b2b_ack0", {31'd0, wr_ack}, 32'd1);
    step();
    check("b2b_gap", {31'd0, wr_ack}, 32'd0);
    step();
    check("b2b_ack1", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    step();

    // Commit with vblank low for 100 cycles; write held meanwhile is stalled
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    check("pend_busy", {31'd0, busy}, 32'd1);
    wr_req  = 1'b1;
    wr_addr = 4'd6;
    wr_data = 17'h00040;
    seen    = 0;
    repeat (100) begin
      step();
      if (wr_ack) seen++;
    end
    check("pend_no_ack", seen, 0);
    check("pend_no_done", {31'd0, commit_done}, 32'd0);
    vblank = 1'b1;
    n      = 0;
    while (!commit_done && n < 40) begin
      step();
      n++;
      if (wr_ack) seen++;
      if (n == 5) vblank = 1'b0;  // vblank falls mid-copy
    end
    check("vblank_to_done", n, 17);
    check("copy_no_ack", seen, 0);
    step();
    check("done_pulse", {31'd0, commit_done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("idle_ack_wait", {31'd0, wr_ack}, 32'd0);
    step();
    check("stalled_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    step();
    read_tile(4'd5, v);
    check("commit_11", {15'd0, v}, 32'h800);
    read_tile(4'd3, v);
    check("commit_03", {15'd0, v}, 32'h777);
    // Read holds without pix_stb
    row = 2'd0;
    col = 2'd0;
    step();
    check("data_hold", {15'd0, data}, 32'h777);
    read_tile(4'd6, v);
    check("late_write_hidden", {15'd0, v}, 32'd0);

    // Commit with vblank already high, same cycle as a write; second commit ignored
    commit_req = 1'b1;
    vblank     = 1'b1;
    wr_req     = 1'b1;
    wr_addr    = 4'd9;
    wr_data    = 17'h00055;
    step();
    check("commit_wins", {31'd0, wr_ack}, 32'd0);
    commit_req = 1'b0;
    wr_req     = 1'b0;
    n          = 1;
    while (!commit_done && n < 40) begin
      step();
      n++;
      commit_req = (n == 3);
    end
    commit_req = 1'b0;
    vblank     = 1'b0;
    check("commit_latency", n, 18);
    step();
    step();
    check("ignored_commit", {31'd0, busy}, 32'd0);
    read_tile(4'd6, v);
    check("commit_12", {15'd0, v}, 32'h40);
    read_tile(4'd9, v);
    check("stalled_write_lost", {15'd0, v}, 32'd0);

    // Reset while COPY is at idx 7
    commit_req = 1'b1;
    vblank     = 1'b1;
    step();
    commit_req = 1'b0;
    repeat (8) step();
    check("copy_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    vblank = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {15'd0, data}, 32'd0);
    check("midrst_done", {31'd0, commit_done}, 32'd0);
    seen = 0;
    repeat (20) begin
      step();
      if (commit_done) seen++;
    end
    check("midrst_no_done", seen, 0);
    do_commit(n);
    check("postrst_latency", n, 18);
    for (int t = 0; t < 16; t++) begin
      read_tile(t[3:0], v);
      check("postrst_tile", {15'd0, v}, 32'd0);
    end

`ifdef BOARD_FB_CLEAR_EN
    for (int t = 0; t < 16; t++) do_write(t[3:0], 17'h2);
    do_commit(n);
    read_tile(4'd15, v);
    check("fill_front", {15'd0, v}, 32'h2);
    clear_req  = 1'b1;
    commit_req = 1'b1;
    step();
    clear_req  = 1'b0;
    commit_req = 1'b0;
    n          = 1;
    while (!clear_done && n < 40) begin
      step();
      n++;
    end
    check("clear_latency", n, 17);
    check("clear_wins", {31'd0, busy}, 32'd0);
    read_tile(4'd0, v);
    check("front_untouched", {15'd0, v}, 32'h2);
    do_commit(n);
    check("clear_commit_lat", n, 18);
    for (int t = 0; t < 16; t++) begin
      read_tile(t[3:0], v);
      check("cleared_tile", {15'd0, v}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
